// File: rtl/pipelined_adder.sv
// WIDTH-bit pipelined adder: STAGES chunk-adders with registered carry ripple and valid/ready flow control.
// Optional subtraction port enabled by defining PIPELINED_ADDER_SUB_EN.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned CHUNK = WIDTH / STAGES;
  localparam int unsigned OPS   = (STAGES > 1) ? STAGES - 1 : 1;

  if ((STAGES == 0) || (WIDTH % STAGES != 0)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic                          advance;
  logic [WIDTH-1:0]              b_eff;
  logic                          cin_eff;

  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0]             carry_q, carry_d;
  logic [STAGES-1:0][WIDTH-1:0]  sum_q, sum_d;
  logic [OPS-1:0][WIDTH-1:0]     a_q, a_d;
  logic [OPS-1:0][WIDTH-1:0]     b_q, b_d;
  logic                          ovf_q, ovf_d;

  logic [STAGES-1:0][WIDTH-1:0]  op_a, op_b, op_s;
  logic [STAGES-1:0]             op_c, op_v;
  logic [STAGES-1:0][CHUNK:0]    add_r;
  logic                          msb_cin;

  // Subtraction folds into the datapath as a + ~b + 1 before stage 0.
  always_comb begin
`ifdef PIPELINED_ADDER_SUB_EN
    b_eff   = sub ? ~b : b;
    cin_eff = sub ? 1'b1 : c_in;
`else
    b_eff   = b;
    cin_eff = c_in;
`endif
  end

  always_comb begin
    advance  = !(valid_q[STAGES-1] && !out_ready);
    in_ready = advance;
  end

  // Operand skew registers shift right each stage, so the active chunk is always in the low bits.
  always_comb begin
    op_a[0] = a;
    op_b[0] = b_eff;
    op_c[0] = cin_eff;
    op_s[0] = '0;
    op_v[0] = in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      op_a[k] = a_q[k-1];
      op_b[k] = b_q[k-1];
      op_c[k] = carry_q[k-1];
      op_s[k] = sum_q[k-1];
      op_v[k] = valid_q[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      add_r[k] = {1'b0, op_a[k][CHUNK-1:0]} + {1'b0, op_b[k][CHUNK-1:0]}
               + (CHUNK+1)'(op_c[k]);
    end
    msb_cin = op_a[STAGES-1][CHUNK-1] ^ op_b[STAGES-1][CHUNK-1] ^ add_r[STAGES-1][CHUNK-1];
  end

  // Partial sums enter from the top and shift down, landing aligned after the last stage.
  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    a_d     = a_q;
    b_d     = b_q;
    ovf_d   = ovf_q;
    if (advance) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid_d[k] = op_v[k];
        carry_d[k] = add_r[k][CHUNK];
        sum_d[k]   = (op_s[k] >> CHUNK)
                   | (WIDTH'(add_r[k][CHUNK-1:0]) << (WIDTH - CHUNK));
      end
      for (int unsigned k = 0; k + 1 < STAGES; k++) begin
        a_d[k] = op_a[k] >> CHUNK;
        b_d[k] = op_b[k] >> CHUNK;
      end
      ovf_d = msb_cin ^ add_r[STAGES-1][CHUNK];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      sum_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    out_valid = valid_q[STAGES-1];
    sum       = sum_q[STAGES-1];
    carry_out = carry_q[STAGES-1];
    overflow  = ovf_q;
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=8, STAGES=4): directed table, random stream,
// backpressure, mid-stream reset, and subtraction vectors when PIPELINED_ADDER_SUB_EN is defined.
module tb_pipelined_adder;

  localparam int W = 8;
  localparam int S = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         cin_i = 1'b0;
  logic         sub_i = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int delivered = 0;
  res_t exp_q[$];
  res_t mon_r;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .c_in      (cin_i),
`ifdef PIPELINED_ADDER_SUB_EN
    .sub       (sub_i),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    res_t r;
    int unsigned bb, total;
    bb    = sub ? ((~int'(b)) & 32'hFF) : int'(b);
    total = int'(a) + bb + (sub ? 1 : int'(cin));
    r.s   = total[W-1:0];
    r.co  = total[W];
    r.ov  = (a[W-1] == bb[W-1]) && (total[W-1] != a[W-1]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: transfers are decided by values stable between the drive point and the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got output %0h expected no output at %0t", sum, $time);
        end else begin
          mon_r = exp_q.pop_front();
          chk("sb_sum", 32'(sum), 32'(mon_r.s));
          chk("sb_cout", 32'(carry_out), 32'(mon_r.co));
          chk("sb_ovf", 32'(overflow), 32'(mon_r.ov));
          delivered++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a_i, b_i, cin_i, sub_i));
        accepted++;
      end
    end
  end

  task automatic run_vec(input string tag, input vec_t v);
    a_i = v.a; b_i = v.b; cin_i = v.cin; sub_i = v.sub;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    sub_i = 1'b0;
    for (int c = 1; c <= S; c++) begin
      if (c > 1) tick();
      if (c < S) begin
        chk({tag, "_early"}, 32'(out_valid), 32'd0);
      end else begin
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(sum), 32'(v.s));
        chk({tag, "_cout"}, 32'(carry_out), 32'(v.co));
        chk({tag, "_ovf"}, 32'(overflow), 32'(v.ov));
      end
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t dir[8];
    vec_t sv[2];
    logic [W-1:0] ra, rb;
    int ones, rises;
    logic prev_v;
    int filled;

    dir[0] = '{a:8'hFF, b:8'h01, cin:1'b0, sub:1'b0, s:8'h00, co:1'b1, ov:1'b0};
    dir[1] = '{a:8'h7F, b:8'h01, cin:1'b0, sub:1'b0, s:8'h80, co:1'b0, ov:1'b1};
    dir[2] = '{a:8'h80, b:8'h80, cin:1'b0, sub:1'b0, s:8'h00, co:1'b1, ov:1'b1};
    dir[3] = '{a:8'hFF, b:8'hFF, cin:1'b1, sub:1'b0, s:8'hFF, co:1'b1, ov:1'b0};
    dir[4] = '{a:8'h00, b:8'h00, cin:1'b1, sub:1'b0, s:8'h01, co:1'b0, ov:1'b0};
    dir[5] = '{a:8'h55, b:8'hAA, cin:1'b1, sub:1'b0, s:8'h00, co:1'b1, ov:1'b0};
    dir[6] = '{a:8'h40, b:8'h40, cin:1'b0, sub:1'b0, s:8'h80, co:1'b0, ov:1'b1};
    dir[7] = '{a:8'h0F, b:8'h01, cin:1'b0, sub:1'b0, s:8'h10, co:1'b0, ov:1'b0};
    sv[0]  = '{a:8'h05, b:8'h07, cin:1'b0, sub:1'b1, s:8'hFE, co:1'b0, ov:1'b0};
    sv[1]  = '{a:8'h80, b:8'h01, cin:1'b1, sub:1'b1, s:8'h7F, co:1'b1, ov:1'b1};

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(carry_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();

    // Directed table with exact latency
    for (int i = 0; i < 8; i++) run_vec("dir", dir[i]);

    // Back-to-back random stream, first 8 cover every LSB full-adder combination
    ones = 0; rises = 0; prev_v = 1'b0;
    for (int i = 0; i < 16 + S + 4; i++) begin
      if (i < 16) begin
        ra = W'($urandom); rb = W'($urandom);
        cin_i = (i < 8) ? 1'(i >> 2) : 1'($urandom_range(0, 1));
        if (i < 8) begin
          ra[0] = 1'(i);
          rb[0] = 1'(i >> 1);
        end
        a_i = ra; b_i = rb; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) ones++;
      if (out_valid && !prev_v) rises++;
      prev_v = out_valid;
      tick();
    end
    chk("stream_count", 32'(ones), 32'd16);
    chk("stream_contiguous", 32'(rises), 32'd1);

    // Backpressure with a full pipeline
    accepted = 0; delivered = 0;
    out_ready = 1'b1; filled = 0;
    for (int i = 0; i < 10 && filled == 0; i++) begin
      if (out_valid) begin
        filled = 1;
      end else begin
        a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        tick();
      end
    end
    chk("bp_fill", 32'(filled), 32'd1);
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b0;
      a_i = W'($urandom); b_i = W'($urandom); in_valid = 1'b1;
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      if (exp_q.size() > 0) begin
        chk("bp_hold_sum", 32'(sum), 32'(exp_q[0].s));
        chk("bp_hold_cout", 32'(carry_out), 32'(exp_q[0].co));
        chk("bp_hold_ovf", 32'(overflow), 32'(exp_q[0].ov));
      end
      tick();
    end
    out_ready = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < S + 4; i++) tick();
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_no_loss", 32'(delivered), 32'(accepted));

    // Random valid/ready traffic
    for (int i = 0; i < 60; i++) begin
      a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < S + 4; i++) tick();
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      a_i = W'($urandom); b_i = W'($urandom) | 8'h01; cin_i = 1'b1; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(carry_out), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < S + 6; i++) begin
      tick();
      chk("post_rst_stale", 32'(out_valid), 32'd0);
    end
    run_vec("post_rst", dir[0]);

`ifdef PIPELINED_ADDER_SUB_EN
    for (int i = 0; i < 2; i++) run_vec("sub", sv[i]);
`endif
    chk("final_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the single-bit full adder: WIDTH-bit a + b + c_in, split into STAGES chunk-adders, one chunk per pipeline stage, with carry rippled stage to stage through registers.
- Valid/ready streaming interface with full backpressure; one result per cycle when not stalled.
- Used as the datapath adder primitive for upcoming accumulator and ALU blocks.

Parameters:
- WIDTH, 32, operand and sum width in bits. Must be a multiple of STAGES; elaboration error otherwise.
- STAGES, 4, pipeline depth and chunk count. CHUNK = WIDTH/STAGES. STAGES=1 gives a single registered adder.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b, c_in are valid this cycle.
- in_ready  output  1  adder can accept an operand set this cycle.
- a  input  WIDTH  operand A, unsigned/two's complement agnostic.
- b  input  WIDTH  operand B.
- c_in  input  1  carry into bit 0.
- out_valid  output  1  sum, carry_out and overflow are valid.
- out_ready  input  1  downstream accepts the result this cycle.
- sum  output  WIDTH  (a + b + c_in) mod 2^WIDTH.
- carry_out  output  1  carry out of bit WIDTH-1.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n low, async): every stage valid bit = 0; out_valid = 0, sum = 0, carry_out = 0, overflow = 0. In-flight operations are discarded, not completed. After deassertion the first accept happens no earlier than the next rising edge.
- advance = !(out_valid && !out_ready). in_ready = advance (combinational, no dependency on in_valid).
- Transfer in: in_valid && in_ready at an edge. Transfer out: out_valid && out_ready at an edge.
- When advance = 1, all stages shift one position. Each stage valid bit takes the previous stage's valid bit; stage 0 takes in_valid. Bubbles propagate as valid = 0 and are not compacted.
- When advance = 0, every stage register holds. sum, carry_out and overflow stay stable while out_valid && !out_ready.
- Stage k (0..STAGES-1):
  - Adds chunk k of a and b, i.e. bits [k*CHUNK +: CHUNK], plus the registered carry from stage k-1. Stage 0 uses c_in.
  - Registers a CHUNK-bit partial sum and a 1-bit carry.
  - Operand chunks above k ride along in skew registers.
  - Completed lower chunks ride along in de-skew registers, so the final stage presents an aligned WIDTH-bit sum.
- Latency: exactly STAGES cycles from accept to out_valid with out_ready held high. Throughput: 1 per cycle. Stalls add cycles one for one.
- Simultaneous accept and deliver in the same cycle is legal and loses nothing.
- overflow is computed in the last stage from the MSB carry-in and carry-out.
- Wrap-around: the sum is modulo 2^WIDTH; carry_out and overflow report the condition and never saturate.
- Data registers of invalid stages may hold stale values. Outputs are defined only while out_valid = 1, except at reset.

Optional Feature:
- Macro: PIPELINED_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with a and b and carried down the pipeline with its operand set.
  - When sub = 1, the adder computes a - b as a + ~b + 1; c_in is ignored, and carry_out = 1 means no borrow.
  - overflow uses the same MSB rule.
  - When sub = 0, behaviour is identical to the macro-undefined build.
- Undefined: no sub port; addition only.

Test Plan:
- WIDTH=8, STAGES=4, out_ready=1: a=0xFF, b=0x01, c_in=0 -> after exactly 4 cycles sum=0x00, carry_out=1, overflow=0 (the carry ripples through all 4 chunks).
- WIDTH=8, STAGES=4: a=0x7F, b=0x01, c_in=0 -> sum=0x80, carry_out=0, overflow=1. Then a=0x80, b=0x80 -> sum=0x00, carry_out=1, overflow=1.
- Back-to-back stream of 16 random operand sets with in_valid=1, out_ready=1 -> 16 consecutive out_valid cycles, in order, each matching the reference model (a+b+c_in), including all 8 single-bit full-adder combinations in the LSB.
- Backpressure: out_ready low for 5 cycles with a full pipeline -> in_ready=0 throughout, outputs held stable, no result lost or duplicated after out_ready returns to 1.
- Assert rst_n low mid-stream with 3 operations in flight -> out_valid=0, sum=0 immediately (asynchronous). After release, no stale result ever appears.
- PIPELINED_ADDER_SUB_EN: a=0x05, b=0x07, sub=1 -> sum=0xFE, carry_out=0. a=0x80, b=0x01, sub=1 -> sum=0x7F, overflow=1.
